// File: rtl/bitserial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_pkg
// Brief    : Shared types and defaults for the bit-serial add controller.
// Revision : 1.0 - initial release
// ============================================================================
package bitserial_pkg;

  // Controller phases: waiting for operands, walking the bits, holding result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default operand/result width
  localparam int DEF_WIDTH = 8;

endpackage : bitserial_pkg
`default_nettype wire

// File: rtl/bitserial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_add_ctrl
// Brief    : Drives an external 1-bit full-adder slice LSB-first, one bit per
//            clock, feeding the carry back through a register, and returns
//            the reassembled WIDTH-bit sum plus carry-out over a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bitserial_add_ctrl
  import bitserial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_ci,
  input  logic             add_sum,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_shift;

  // Sequencing, operand shifting, sum collection and carry feedback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= op_a;
            r_b_sh  <= op_b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          // Sum bits enter at the MSB so bit 0 settles in result[0] at the end
          r_res   <= {add_sum, r_res[WIDTH-1:1]};
          r_carry <= add_co;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; slice inputs are quiet
  // outside SHIFT. The carry register is untouched between DONE and the
  // next accept, so it doubles as the held carry-out.
  always_comb begin
    w_shift   = (r_state == S_SHIFT);
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    add_a     = w_shift & r_a_sh[0];
    add_b     = w_shift & r_b_sh[0];
    add_ci    = w_shift & r_carry;
    result    = r_res;
    cout      = r_carry;
  end

endmodule : bitserial_add_ctrl
`default_nettype wire

// File: doc/bitserial_add_ctrl.md
# bitserial_add_ctrl

Bit-serial add controller that drives an external combinational 1-bit full-adder slice and collects its outputs. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It feeds the operands to the slice LSB-first, one bit per clock, with the carry fed back through a register. It then returns the reassembled WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between a word-level requester and the adder slice, and provides both the slice's input driver and its output collector.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  controller can accept operands.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- cin  in  1  carry-in for the word add.
- add_a  out  1  current A bit to the slice.
- add_b  out  1  current B bit to the slice.
- add_ci  out  1  current carry to the slice.
- add_sum  in  1  sum bit from the slice (combinational, same cycle).
- add_co  in  1  carry-out from the slice (combinational, same cycle).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum bits.
- cout  out  1  final carry-out.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch op_a and op_b into shift registers, set carry_q=cin, clear bit counter, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - add_a=a_sh[0], add_b=b_sh[0], add_ci=carry_q.
  - Each edge:
    - shift a_sh and b_sh right by 1.
    - shift add_sum into the result register at the MSB (shift right), so that bit 0 lands in result[0] after WIDTH shifts.
    - carry_q<=add_co.
    - counter+1.
  - The edge where counter==WIDTH-1 also goes to DONE.
- DONE:
  - out_valid=1.
  - result and cout (=carry_q) are held stable.
  - On out_ready go to IDLE.
- Slice drive outside SHIFT: add_a, add_b and add_ci are 0 in IDLE and DONE.
- Result register and cout keep the last value in IDLE. They are only meaningful while out_valid=1.
- Arithmetic: {cout,result} = op_a + op_b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Counter width is $clog2(WIDTH); the counter never wraps past WIDTH-1.
- in_valid while not in IDLE is ignored (no accept). Operands must be held by the requester until accepted.
- Reset mid-operation:
  - the operation is aborted immediately and no out_valid is produced.
  - the next accepted operation is computed correctly.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1 (combinational from IDLE).
  - out_valid=0, result=0, cout=0.
  - add_a=0, add_b=0, add_ci=0.
  - carry_q, counter and shift registers all 0.
- Accept at edge E0 → SHIFT during cycles E0..E(WIDTH).
- Bit i is presented to the slice in the cycle after edge E(i) and is captured at edge E(i+1).
- out_valid rises after edge E(WIDTH): the latency from accept to valid is WIDTH cycles.
- If out_ready is already 1, the DONE→IDLE transition happens at the next edge and in_ready returns one cycle later.
- Minimum spacing between accepts is WIDTH+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package bitserial_pkg holds:
  - typedef enum state_t {IDLE, SHIFT, DONE}.
  - the default WIDTH localparam.
- No sub-module inside the block. The full-adder slice is external, and the bench instantiates the existing 1-bit adder model and connects it to add_* ports.
- Expected size is about 150 lines of RTL.

## Test plan
- WIDTH=8, op_a=0x03, op_b=0x05, cin=0, out_ready=1 → out_valid 8 cycles after accept, result=0x08, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 → result=0x00, cout=1. Per-cycle add_ci sequence is 0,1,1,1,1,1,1,1.
- op_a=0xFF, op_b=0xFF, cin=1 → result=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → result and cout stay stable and in_valid is ignored with in_ready=0. Result is accepted on the cycle out_ready=1, with in_ready=1 one cycle later.
- rst_n pulsed low during SHIFT at bit 3 → all outputs at reset values asynchronously and no out_valid ever appears. The next op 0x10+0x20 cin=0 gives 0x30, cout=0.
- Back-to-back: 20 random operand triples with in_valid held high → every result matches the reference sum and accept spacing is exactly WIDTH+2 cycles.
